// File: rtl/mem_client_reader_if.sv
// Signal bundle for mem_client_reader: job control, memory-farm request/response
// and the downstream buffered-line stream.
interface mem_client_reader_if #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned LEN_WIDTH  = 16
);
    logic                  job_start;
    logic [ADDR_WIDTH-1:0] job_addr;
    logic [LEN_WIDTH-1:0]  job_len;
    logic                  job_busy;
    logic                  job_done;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_start_addr;
    logic [4:0]            mem_size_bytes;
    logic                  mem_valid;
    logic [255:0]          mem_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [255:0]          out_data;
    logic [5:0]            out_bytes;
    logic                  out_last;
    logic                  err_unexp;

    // Reader side
    modport master (
        input  job_start, job_addr, job_len, mem_valid, mem_data, out_ready,
        output job_busy, job_done, mem_req, mem_start_addr, mem_size_bytes,
               out_valid, out_data, out_bytes, out_last, err_unexp
    );

    // Job issuer, memory farm and downstream consumer side
    modport slave (
        output job_start, job_addr, job_len, mem_valid, mem_data, out_ready,
        input  job_busy, job_done, mem_req, mem_start_addr, mem_size_bytes,
               out_valid, out_data, out_bytes, out_last, err_unexp
    );
endinterface

// File: rtl/mem_client_reader.sv
// Memory-farm read client: splits a byte-addressed read job into chunks that never
// cross a 32-byte line, keeps one request outstanding, and buffers responses in a
// 2-entry FIFO toward a valid/ready consumer.
module mem_client_reader #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_client_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [5:0]            chunk_q;
    logic                  job_busy_q;
    logic                  job_done_q;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [4:0]            mem_size_q;
    logic                  err_q;

    // FIFO head lives in the output registers, the second entry in sec_*
    logic [1:0]            fifo_cnt;
    logic [255:0]          out_data_q;
    logic [5:0]            out_bytes_q;
    logic                  out_last_q;
    logic [255:0]          sec_data;
    logic [5:0]            sec_bytes;
    logic                  sec_last;

    logic [5:0]            first_chunk;
    logic [5:0]            next_chunk;
    logic                  push;
    logic                  pop;
    logic                  push_last;

    // Bytes until the end of the current 32-byte line, capped by what is left of the job
    function automatic logic [5:0] chunk_of(input logic [4:0] lo, input logic [LEN_WIDTH-1:0] rem);
        logic [5:0] room;
        room = 6'd32 - {1'b0, lo};
        if (rem < LEN_WIDTH'(room))
            chunk_of = rem[5:0];
        else
            chunk_of = room;
    endfunction

    // Chunk sizes for a freshly launched job and for the continuation of the current job
    always_comb begin
        first_chunk = chunk_of(bus.job_addr[4:0], bus.job_len);
        next_chunk  = chunk_of(addr_q[4:0], rem_q);
    end

    assign push      = (state == WAIT) && bus.mem_valid;
    assign pop       = (fifo_cnt != 2'd0) && bus.out_ready;
    assign push_last = (rem_q == LEN_WIDTH'(chunk_q));

    // Job sequencer. The FIFO is always empty in IDLE, so the first chunk is issued
    // straight from IDLE (passing through REQ without a dwell cycle); this is what
    // gives mem_req one cycle after job_start. REQ then gates later chunks on FIFO room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            chunk_q    <= '0;
            job_busy_q <= 1'b0;
            job_done_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_size_q <= '0;
            err_q      <= 1'b0;
        end else begin
            job_done_q <= 1'b0;
            if (bus.mem_valid && (state != WAIT))
                err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.job_start) begin
                        if (bus.job_len == '0) begin
                            job_done_q <= 1'b1;
                        end else begin
                            job_busy_q <= 1'b1;
                            addr_q     <= bus.job_addr;
                            rem_q      <= bus.job_len;
                            chunk_q    <= first_chunk;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= bus.job_addr;
                            mem_size_q <= 5'(first_chunk - 6'd1);
                            state      <= WAIT;
                        end
                    end
                end
                REQ: begin
                    if (fifo_cnt != 2'd2) begin
                        chunk_q    <= next_chunk;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= addr_q;
                        mem_size_q <= 5'(next_chunk - 6'd1);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_valid) begin
                        mem_req_q <= 1'b0;
                        addr_q    <= addr_q + ADDR_WIDTH'(chunk_q);
                        rem_q     <= rem_q - LEN_WIDTH'(chunk_q);
                        state     <= push_last ? DRAIN : REQ;
                    end
                end
                DRAIN: begin
                    if (fifo_cnt == 2'd0) begin
                        job_done_q <= 1'b1;
                        job_busy_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry response FIFO with registered head; a push into a full FIFO cannot
    // happen because a request is only issued while fewer than two entries are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt    <= 2'd0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_last_q  <= 1'b0;
            sec_data    <= '0;
            sec_bytes   <= '0;
            sec_last    <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        out_data_q  <= bus.mem_data;
                        out_bytes_q <= chunk_q;
                        out_last_q  <= push_last;
                    end else begin
                        sec_data    <= bus.mem_data;
                        sec_bytes   <= chunk_q;
                        sec_last    <= push_last;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    if (fifo_cnt == 2'd2) begin
                        out_data_q  <= sec_data;
                        out_bytes_q <= sec_bytes;
                        out_last_q  <= sec_last;
                    end
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        out_data_q  <= bus.mem_data;
                        out_bytes_q <= chunk_q;
                        out_last_q  <= push_last;
                    end else begin
                        out_data_q  <= sec_data;
                        out_bytes_q <= sec_bytes;
                        out_last_q  <= sec_last;
                        sec_data    <= bus.mem_data;
                        sec_bytes   <= chunk_q;
                        sec_last    <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.job_busy       = job_busy_q;
    assign bus.job_done       = job_done_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_start_addr = mem_addr_q;
    assign bus.mem_size_bytes = mem_size_q;
    assign bus.out_valid      = (fifo_cnt != 2'd0);
    assign bus.out_data       = out_data_q;
    assign bus.out_bytes      = out_bytes_q;
    assign bus.out_last       = out_last_q;
    assign bus.err_unexp      = err_q;
endmodule

// File: tb/tb_mem_client_reader.sv
// Testbench for mem_client_reader: directed job table, randomized jobs against a
// chunk-list reference model, plus hand sequences for reset and stray responses.
`timescale 1ns/1ps
module tb_mem_client_reader;
    localparam int unsigned AW = 19;
    localparam int unsigned LW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_client_reader_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();
    mem_client_reader #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { int unsigned addr; int unsigned bytes; bit last; } chunk_t;
    typedef struct { logic [255:0] data; int unsigned bytes; bit last; } beat_t;
    typedef struct {
        int unsigned addr, len, dly, pct, stall;
        bit          poke;
        int unsigned exp_nreq, exp_first, exp_last;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},  bus.job_busy, 0);
        chk({pfx, "_done"},  bus.job_done, 0);
        chk({pfx, "_req"},   bus.mem_req, 0);
        chk({pfx, "_addr"},  bus.mem_start_addr, 0);
        chk({pfx, "_size"},  bus.mem_size_bytes, 0);
        chk({pfx, "_ovld"},  bus.out_valid, 0);
        chk({pfx, "_odata"}, bus.out_data, 0);
        chk({pfx, "_obyte"}, bus.out_bytes, 0);
        chk({pfx, "_olast"}, bus.out_last, 0);
        chk({pfx, "_err"},   bus.err_unexp, 0);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20 && !bus.mem_req; i++) @(negedge clk);
        chk(name, bus.mem_req, 1);
    endtask

    // Runs one job from a negedge to the negedge after job_done, acting as memory farm
    // (response dly cycles after a request is first seen) and consumer (ready with
    // probability pct%, forced low for the first `stall` cycles).
    task automatic run_job(input int unsigned a, input int unsigned l, input int unsigned dly,
                           input int unsigned pct, input int unsigned stall, input bit poke,
                           output int unsigned nreq, output int unsigned first_b,
                           output int unsigned last_b);
        chunk_t      req_q[$];
        beat_t       beat_q[$];
        chunk_t      ch;
        beat_t       bt, held;
        int unsigned rem, cur, room, cnt, cyc, ndone, npop;
        bit          vld_last, stalled, rdy;

        // Reference: the job is cut at every 32-byte line boundary
        rem = l;
        cur = a;
        while (rem > 0) begin
            room     = 32 - (cur % 32);
            ch.bytes = (rem < room) ? rem : room;
            ch.addr  = cur;
            ch.last  = (rem == ch.bytes);
            req_q.push_back(ch);
            cur = (cur + ch.bytes) % (32'd1 << AW);
            rem -= ch.bytes;
        end

        nreq = 0; first_b = 0; last_b = 0;
        cnt = 0; cyc = 0; ndone = 0; npop = 0; vld_last = 0; stalled = 0;

        bus.job_addr  = AW'(a);
        bus.job_len   = LW'(l);
        bus.job_start = 1'b1;
        @(negedge clk);
        bus.job_start = 1'b0;
        bus.job_addr  = AW'($urandom);
        bus.job_len   = LW'($urandom);

        while (ndone == 0 && cyc < 4000) begin
            if (cyc == 0) begin
                chk("start_to_req", bus.mem_req, l != 0);
                chk("zero_len_done", bus.job_done, l == 0);
            end
            if (bus.job_done) ndone++;
            chk("job_busy", bus.job_busy, (l != 0) && (ndone == 0));

            // A second launch while busy must be ignored
            bus.job_start = poke && (cyc == 3);
            if (poke && cyc == 3) begin
                bus.job_addr = AW'($urandom);
                bus.job_len  = LW'($urandom_range(1, 100));
            end

            // Memory farm
            if (vld_last) begin
                bus.mem_valid = 1'b0;
                vld_last      = 1'b0;
                chk("valid_to_out", bus.out_valid, 1);
                chk("req_drop", bus.mem_req, 0);
            end else if (bus.mem_req) begin
                if (req_q.size() == 0) begin
                    chk("extra_req", bus.mem_req, 0);
                end else begin
                    if (cnt == 0) nreq++;
                    chk("req_addr", bus.mem_start_addr, AW'(req_q[0].addr));
                    chk("req_size", bus.mem_size_bytes, 5'(req_q[0].bytes - 1));
                    if (cnt == dly) begin
                        for (int i = 0; i < 8; i++) bt.data[i*32 +: 32] = $urandom;
                        bt.bytes = req_q[0].bytes;
                        bt.last  = req_q[0].last;
                        bus.mem_valid = 1'b1;
                        bus.mem_data  = bt.data;
                        beat_q.push_back(bt);
                        void'(req_q.pop_front());
                        chk("fifo_depth", beat_q.size() <= 2, 1);
                        vld_last = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end

            // Consumer
            if (bus.out_valid && stalled) begin
                chk("hold_data",  bus.out_data,  held.data);
                chk("hold_bytes", bus.out_bytes, held.bytes);
                chk("hold_last",  bus.out_last,  held.last);
            end
            if (stall != 0 && cyc == stall) begin
                chk("stall_reqs", nreq, 2);
                chk("stall_req_low", bus.mem_req, 0);
            end
            rdy = (cyc >= stall) && ($urandom_range(99) < pct);
            bus.out_ready = rdy;
            stalled = 1'b0;
            if (bus.out_valid) begin
                if (beat_q.size() == 0) begin
                    chk("extra_out", bus.out_valid, 0);
                end else if (rdy) begin
                    chk("out_data",  bus.out_data,  beat_q[0].data);
                    chk("out_bytes", bus.out_bytes, beat_q[0].bytes);
                    chk("out_last",  bus.out_last,  beat_q[0].last);
                    if (npop == 0) first_b = bus.out_bytes;
                    last_b = bus.out_bytes;
                    npop++;
                    void'(beat_q.pop_front());
                end else begin
                    stalled    = 1'b1;
                    held.data  = bus.out_data;
                    held.bytes = bus.out_bytes;
                    held.last  = bus.out_last;
                end
            end
            @(negedge clk);
            cyc++;
        end

        if (ndone == 0) chk("job_done_timeout", ndone, 1);
        chk("reqs_left", req_q.size(), 0);
        chk("beats_left", beat_q.size(), 0);
        chk("err_clear", bus.err_unexp, 0);
        chk("done_pulse", bus.job_done, 0);
        chk("idle_busy", bus.job_busy, 0);
    endtask

    initial begin
        vec_t        vecs[10];
        int unsigned nreq, fb, lb;

        rst_n         = 1'b0;
        bus.job_start = 1'b0;
        bus.job_addr  = '0;
        bus.job_len   = '0;
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        //          addr      len  dly pct  stall poke  nreq first last
        vecs[0] = '{32'h40,    64,  3, 100,  0,   0,    2,  32,  32};
        vecs[1] = '{32'h1D,    40,  3, 100,  0,   0,    3,   3,   5};
        vecs[2] = '{32'h00,     0,  0, 100,  0,   0,    0,   0,   0};
        vecs[3] = '{32'h80,   128,  1, 100, 40,   0,    4,  32,  32};
        vecs[4] = '{32'h7FFF0, 48,  0,  50,  0,   0,    2,  16,  32};
        vecs[5] = '{32'h05,     1,  2, 100,  0,   0,    1,   1,   1};
        vecs[6] = '{32'h1F,     2,  0,  70,  0,   0,    2,   1,   1};
        vecs[7] = '{32'h00,   200,  2,  60,  0,   1,    7,  32,   8};
        vecs[8] = '{32'h03,    29,  1, 100,  0,   0,    1,  29,  29};
        vecs[9] = '{32'h03,    30,  1, 100,  0,   0,    2,  29,   1};

        for (int i = 0; i < 10; i++) begin
            run_job(vecs[i].addr, vecs[i].len, vecs[i].dly, vecs[i].pct, vecs[i].stall,
                    vecs[i].poke, nreq, fb, lb);
            chk($sformatf("v%0d_nreq", i),  nreq, vecs[i].exp_nreq);
            chk($sformatf("v%0d_first", i), fb,   vecs[i].exp_first);
            chk($sformatf("v%0d_last", i),  lb,   vecs[i].exp_last);
        end

        for (int i = 0; i < 20; i++) begin
            run_job($urandom_range(0, (32'd1 << AW) - 1), $urandom_range(0, 160),
                    $urandom_range(0, 3), $urandom_range(30, 100), 0, 0, nreq, fb, lb);
        end

        // Reset while a second request is outstanding and one line is buffered
        bus.out_ready = 1'b0;
        bus.job_addr  = AW'(32'h100);
        bus.job_len   = LW'(96);
        bus.job_start = 1'b1;
        @(negedge clk);
        bus.job_start = 1'b0;
        wait_req("mr_req1");
        bus.mem_valid = 1'b1;
        bus.mem_data  = {8{32'hA5A5_5A5A}};
        @(negedge clk);
        bus.mem_valid = 1'b0;
        wait_req("mr_req2");
        chk("mr_one_entry", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mr_no_done", bus.job_done, 0);
        end
        run_job(32'h240, 70, 2, 80, 0, 0, nreq, fb, lb);
        chk("mr_next_nreq", nreq, 3);
        chk("mr_next_last", lb, 6);

        // Stray response in IDLE
        bus.mem_valid = 1'b1;
        bus.mem_data  = {8{32'hDEAD_BEEF}};
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("unexp_err", bus.err_unexp, 1);
        chk("unexp_no_out", bus.out_valid, 0);
        repeat (5) @(negedge clk);
        chk("unexp_sticky", bus.err_unexp, 1);
        chk("unexp_no_out2", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_client_reader.md
MEM_CLIENT_READER -- requirements
Module: mem_client_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 19, byte address width toward the memory farm.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, job length width in bytes.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port job_start  input  1  one-cycle pulse launching a read job.
REQ-006 SHALL have port job_addr  input  ADDR_WIDTH  job start byte address, sampled with job_start.
REQ-007 SHALL have port job_len  input  LEN_WIDTH  job length in bytes, sampled with job_start.
REQ-008 SHALL have port job_busy  output  1  high from accepted job_start until job_done.
REQ-009 SHALL have port job_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port mem_req  output  1  read request to memory farm.
REQ-011 SHALL have port mem_start_addr  output  ADDR_WIDTH  request byte address.
REQ-012 SHALL have port mem_size_bytes  output  5  request size minus one (0 = 1 byte, 31 = 32 bytes).
REQ-013 SHALL have port mem_valid  input  1  one-cycle response strobe from memory farm.
REQ-014 SHALL have port mem_data  input  256  response line, byte 0 in bits [7:0].
REQ-015 SHALL have port out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-016 SHALL have port out_data  output  256  buffered response line.
REQ-017 SHALL have port out_bytes  output  6  valid bytes in out_data, 1..32.
REQ-018 SHALL have port out_last  output  1  marks final chunk of job.
REQ-019 SHALL have port err_unexp  output  1  sticky: mem_valid received outside WAIT.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, DRAIN.
REQ-021 IDLE: job_start with job_len>0 -> latch addr/len, job_busy=1, go REQ next cycle.
REQ-022 IDLE: job_start with job_len=0 -> no mem_req, job_done pulse next cycle, stay IDLE.
REQ-023 job_start while job_busy=1 SHALL be ignored.
REQ-024 Chunk size = min(remaining, 32 - addr[4:0]); chunks never cross a 32-byte line.
REQ-025 REQ: assert mem_req only when FIFO holds <2 entries; mem_start_addr/mem_size_bytes stable while mem_req=1; go WAIT same edge mem_req asserted.
REQ-026 WAIT: mem_req held high until mem_valid; mem_valid in WAIT drops mem_req same edge, at most one outstanding request.
REQ-027 On mem_valid: push {mem_data, chunk size, last flag} into 2-entry FIFO; addr += chunk (mod 2^ADDR_WIDTH), remaining -= chunk.
REQ-028 After push: remaining>0 -> REQ; remaining=0 -> DRAIN.
REQ-029 DRAIN: when FIFO empty, pulse job_done one cycle, job_busy=0, go IDLE.
REQ-030 FIFO: out_valid=1 when non-empty; pop on out_valid&out_ready; simultaneous push and pop on full FIFO SHALL NOT occur (REQ-025 guarantees space); push+pop when 1 entry keeps count 1.
REQ-031 out_data/out_bytes/out_last SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-032 mem_valid in IDLE/REQ/DRAIN SHALL be dropped and set err_unexp; err_unexp cleared only by reset.
REQ-033 Minimum latency: job_start to first mem_req = 1 cycle; mem_valid to out_valid = 1 cycle.

Reset
REQ-034 On rst_n=0, asynchronously: FSM=IDLE, FIFO empty, job_busy=0, job_done=0, mem_req=0, mem_start_addr=0, mem_size_bytes=0, out_valid=0, out_data=0, out_bytes=0, out_last=0, err_unexp=0.
REQ-035 Reset mid-job SHALL abandon job and outstanding request; no job_done emitted.

Verification
REQ-036 job_addr=0x40, len=64, out_ready=1, mem_valid 3 cycles after each req -> requests (0x40,31),(0x60,31); out_bytes 32,32; out_last on second; one job_done.
REQ-037 job_addr=0x1D, len=40 -> requests (0x1D,size 2),(0x20,31),(0x40,4); out_bytes 3,32,5.
REQ-038 job_len=0 -> no mem_req, job_done one cycle after job_start, job_busy never high.
REQ-039 out_ready=0, len=128 aligned -> exactly 2 requests answered then mem_req stays low; releasing out_ready resumes; all 4 chunks delivered in order, data unchanged while stalled.
REQ-040 mem_valid pulsed in IDLE -> err_unexp=1 and stays; no out_valid.
REQ-041 rst_n low during WAIT with 1 FIFO entry -> all outputs zero immediately; next job runs normally from fresh address.
